pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It consumes the load-use/branch-operand hazard flag from the hazard detection logic, branch/jump redirects, a decoded HALT, and debug-unit run/step commands. It drives per-stage write enables and flush (bubble) controls plus performance counters. It sits beside the hazard detector in ID and feeds the IF/ID, ID/EX, EX/MEM and MEM/WB latch controls.

Parameters:
NB_COUNT, 32, width of cycle and stall counters (saturating)
N_DRAIN, 4, cycles needed to drain ID..WB after HALT decode
NB_DRAIN, 3, width of drain counter (must hold N_DRAIN)

Ports:
i_clock  in  1  system clock, all state updates on posedge
i_reset  in  1  asynchronous, active-low reset
i_hazard  in  1  stall request from hazard detector (combinational, same cycle)
i_branch_taken  in  1  branch/jump resolved taken in ID, redirect this cycle
i_halt_instr  in  1  HALT decoded in ID
i_debug_mode  in  1  1 = debug unit owns execution (pause/step), 0 = free run
i_step  in  1  single-cycle pulse: advance pipeline one clock (debug mode only)
o_pc_en  out  1  PC register write enable
o_if_id_en  out  1  IF/ID latch enable
o_if_id_flush  out  1  load NOP into IF/ID
o_id_ex_flush  out  1  load bubble into ID/EX
o_back_en  out  1  enable for ID/EX, EX/MEM, MEM/WB latches and register-file write
o_halted  out  1  program finished, pipeline drained
o_step_done  out  1  one-cycle pulse after a debug step executes
o_cycle_count  out  NB_COUNT  clocks with o_back_en=1
o_stall_count  out  NB_COUNT  clocks with hazard stall applied

Behaviour:
- States: RUN, PAUSE, STEP, DRAIN, HALTED. Reset -> RUN. Counters, drain counter, o_step_done = 0. While i_reset low, all enables and flushes are forced 0 and o_halted = 0.
- Enables/flushes are combinational from state and current inputs; no added latency.
- "Advance cycle" (RUN, STEP): o_back_en=1 and the following in priority order:
  1. i_halt_instr: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=0 (HALT proceeds). Next state is DRAIN and the drain counter loads N_DRAIN-1.
  2. i_hazard: pc_en=0, if_id_en=0, id_ex_flush=1. i_branch_taken is ignored (branch operands not ready). o_stall_count increments.
  3. i_branch_taken: pc_en=1, if_id_en=1, if_id_flush=1.
  4. Otherwise pc_en=if_id_en=1, no flush.
- RUN: apply the advance cycle. If i_debug_mode=1 and no HALT, next state is PAUSE. The current cycle still advances.
- PAUSE: all enables 0, no flush, counters hold.
  - i_step=1 -> STEP.
  - i_debug_mode=0 -> RUN.
  - If both are asserted, step wins.
- STEP: exactly one advance cycle, including HALT handling. Next state is PAUSE, or DRAIN on HALT. o_step_done=1 on the following clock for one cycle. i_step pulses arriving in STEP are ignored.
- DRAIN: pc_en=0, if_id_en=0, if_id_flush=1, o_back_en=1. The counter decrements each clock. At 0, next state is HALTED.
  - Debug mode does not pause drain.
  - i_hazard and i_branch_taken are ignored.
- HALTED: all enables 0, o_halted=1. Exit only via reset.
- o_cycle_count increments every clock with o_back_en=1. Both counters saturate at all-ones, no wrap.
- Reset mid-drain or mid-step: state returns to RUN immediately (asynchronous) and counters clear.

Test Plan:
- Reset release with no inputs, 10 clocks -> pc_en=if_id_en=back_en=1, o_cycle_count=10, o_stall_count=0, o_halted=0.
- i_hazard high for 1 clock in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only; o_stall_count=1.
- i_hazard and i_branch_taken high together -> stall response, if_id_flush=0. Next clock, with i_branch_taken alone -> if_id_flush=1, pc_en=1.
- i_halt_instr pulse (N_DRAIN=4) -> DRAIN for 4 clocks with back_en=1 and pc_en=0. o_halted=1 from the 5th clock onward; further inputs have no effect.
- i_debug_mode=1, then 3 clocks idle -> enables 0 and counters frozen. i_step pulse -> exactly one clock of enables, o_step_done pulse next clock. i_debug_mode=0 -> RUN resumes.
- Assert i_reset low during DRAIN (asynchronous, between edges) -> outputs 0 immediately. After release: RUN, counters 0, o_halted=0.

Source files
------------

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline: turns hazard, redirect, HALT and
// debug run/step requests into per-stage latch enables, bubbles and perf counters.
module pipeline_control #(
  parameter int NB_COUNT = 32,
  parameter int N_DRAIN  = 4,
  parameter int NB_DRAIN = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_hazard,
  input  logic                i_branch_taken,
  input  logic                i_halt_instr,
  input  logic                i_debug_mode,
  input  logic                i_step,
  output logic                o_pc_en,
  output logic                o_if_id_en,
  output logic                o_if_id_flush,
  output logic                o_id_ex_flush,
  output logic                o_back_en,
  output logic                o_halted,
  output logic                o_step_done,
  output logic [NB_COUNT-1:0] o_cycle_count,
  output logic [NB_COUNT-1:0] o_stall_count,
  output logic [2:0]          o_state
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_PAUSE  = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t              state, next_state;
  logic [NB_DRAIN-1:0] drain_cnt, drain_next;
  logic                pc_en, if_id_en, if_id_flush, id_ex_flush, back_en, stall;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= ST_RUN;
      drain_cnt     <= '0;
      o_step_done   <= 1'b0;
      o_cycle_count <= '0;
      o_stall_count <= '0;
    end else begin
      state       <= next_state;
      drain_cnt   <= drain_next;
      o_step_done <= (state == ST_STEP);
      if (back_en && (o_cycle_count != '1))
        o_cycle_count <= o_cycle_count + NB_COUNT'(1);
      if (stall && (o_stall_count != '1))
        o_stall_count <= o_stall_count + NB_COUNT'(1);
    end
  end

  always_comb begin
    next_state  = state;
    drain_next  = drain_cnt;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    back_en     = 1'b0;
    stall       = 1'b0;
    case (state)
      ST_RUN, ST_STEP: begin
        back_en = 1'b1;
        if (i_halt_instr) begin
          // HALT itself flows on into ID/EX; only the fetch behind it is squashed.
          if_id_flush = 1'b1;
          next_state  = ST_DRAIN;
          drain_next  = NB_DRAIN'(N_DRAIN - 1);
        end else begin
          if (i_hazard) begin
            // Branch operands are not ready yet, so a concurrent redirect is ignored.
            id_ex_flush = 1'b1;
            stall       = 1'b1;
          end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = i_branch_taken;
          end
          if ((state == ST_STEP) || i_debug_mode)
            next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (i_step)
          next_state = ST_STEP;
        else if (!i_debug_mode)
          next_state = ST_RUN;
      end
      ST_DRAIN: begin
        back_en     = 1'b1;
        if_id_flush = 1'b1;
        if (drain_cnt == '0)
          next_state = ST_HALTED;
        else
          drain_next = drain_cnt - NB_DRAIN'(1);
      end
      ST_HALTED: ;
      default: next_state = ST_RUN;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign o_pc_en       = pc_en & i_reset;
  assign o_if_id_en    = if_id_en & i_reset;
  assign o_if_id_flush = if_id_flush & i_reset;
  assign o_id_ex_flush = id_ex_flush & i_reset;
  assign o_back_en     = back_en & i_reset;
  assign o_halted      = (state == ST_HALTED) & i_reset;
  assign o_state       = state;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: reset, stall, redirect, debug pause/step,
// HALT drain and asynchronous reset during drain.
module tb_pipeline_control;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_hazard = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic        i_halt_instr = 1'b0;
  logic        i_debug_mode = 1'b0;
  logic        i_step = 1'b0;
  logic        o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_back_en;
  logic        o_halted, o_step_done;
  logic [31:0] o_cycle_count, o_stall_count;
  logic [2:0]  o_state;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_control #(.NB_COUNT(32), .N_DRAIN(4), .NB_DRAIN(3)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_hazard(i_hazard),
    .i_branch_taken(i_branch_taken), .i_halt_instr(i_halt_instr),
    .i_debug_mode(i_debug_mode), .i_step(i_step),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_flush(o_id_ex_flush), .o_back_en(o_back_en), .o_halted(o_halted),
    .o_step_done(o_step_done), .o_cycle_count(o_cycle_count),
    .o_stall_count(o_stall_count), .o_state(o_state)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, back_en}
  function automatic logic [4:0] ctl();
    return {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_back_en};
  endfunction

  initial begin
    // Reset asserted
    #1 i_reset = 1'b0;
    #2;
    check("rst_ctl", 32'(ctl()), 32'b00000);
    check("rst_halted", 32'(o_halted), 0);
    check("rst_cycle", o_cycle_count, 0);
    check("rst_stall", o_stall_count, 0);
    check("rst_step_done", 32'(o_step_done), 0);
    @(negedge i_clock) i_reset = 1'b1;
    #1;
    check("run_ctl", 32'(ctl()), 32'b11001);
    repeat (10) tick();
    check("run10_cycle", o_cycle_count, 10);
    check("run10_stall", o_stall_count, 0);
    check("run10_halted", 32'(o_halted), 0);

    // Single hazard stall
    i_hazard = 1'b1;
    #1 check("haz_ctl", 32'(ctl()), 32'b00011);
    tick();
    i_hazard = 1'b0;
    #1 check("haz_after_ctl", 32'(ctl()), 32'b11001);
    check("haz_stall", o_stall_count, 1);
    check("haz_cycle", o_cycle_count, 11);

    // Hazard beats branch, then branch alone redirects
    i_hazard = 1'b1; i_branch_taken = 1'b1;
    #1 check("hazbr_ctl", 32'(ctl()), 32'b00011);
    tick();
    i_hazard = 1'b0;
    #1 check("br_ctl", 32'(ctl()), 32'b11101);
    check("hazbr_stall", o_stall_count, 2);
    tick();
    i_branch_taken = 1'b0;
    check("br_cycle", o_cycle_count, 13);

    // Debug pause: entry cycle still advances
    i_debug_mode = 1'b1;
    #1 check("dbg_entry_ctl", 32'(ctl()), 32'b11001);
    tick();
    check("pause_state", 32'(o_state), 1);
    check("pause_ctl", 32'(ctl()), 32'b00000);
    check("pause_cycle", o_cycle_count, 14);
    repeat (3) tick();
    i_hazard = 1'b1;
    #1 check("pause_haz_ctl", 32'(ctl()), 32'b00000);
    i_hazard = 1'b0;
    check("pause3_cycle", o_cycle_count, 14);
    check("pause3_stall", o_stall_count, 2);

    // Single step
    i_step = 1'b1;
    #1 check("step_req_ctl", 32'(ctl()), 32'b00000);
    tick();
    check("step_state", 32'(o_state), 2);
    check("step_ctl", 32'(ctl()), 32'b11001);
    check("step_done_early", 32'(o_step_done), 0);
    tick();
    i_step = 1'b0;
    check("step_back_state", 32'(o_state), 1);
    check("step_done", 32'(o_step_done), 1);
    check("step_cycle", o_cycle_count, 15);
    check("step_post_ctl", 32'(ctl()), 32'b00000);
    tick();
    check("step_done_clear", 32'(o_step_done), 0);
    check("step_one_only_cycle", o_cycle_count, 15);

    // Leave debug mode
    i_debug_mode = 1'b0;
    tick();
    check("resume_state", 32'(o_state), 0);
    check("resume_ctl", 32'(ctl()), 32'b11001);
    check("resume_cycle", o_cycle_count, 15);

    // HALT and drain; hazard/branch/debug ignored during drain
    i_halt_instr = 1'b1;
    #1 check("halt_ctl", 32'(ctl()), 32'b00101);
    tick();
    i_halt_instr = 1'b0;
    i_hazard = 1'b1; i_branch_taken = 1'b1; i_debug_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drain%0d_ctl", i), 32'(ctl()), 32'b00101);
      check($sformatf("drain%0d_halted", i), 32'(o_halted), 0);
      tick();
    end
    check("halted", 32'(o_halted), 1);
    check("halted_ctl", 32'(ctl()), 32'b00000);
    check("halted_cycle", o_cycle_count, 20);
    check("halted_stall", o_stall_count, 2);
    i_step = 1'b1; i_debug_mode = 1'b0;
    tick(); tick();
    i_step = 1'b0; i_hazard = 1'b0; i_branch_taken = 1'b0;
    check("halted_sticky", 32'(o_halted), 1);
    check("halted_sticky_cycle", o_cycle_count, 20);

    // Reset from halted, then reset mid-drain
    i_reset = 1'b0;
    #1 check("rst2_halted", 32'(o_halted), 0);
    @(negedge i_clock) i_reset = 1'b1;
    tick(); tick();
    check("rst2_cycle", o_cycle_count, 2);
    i_halt_instr = 1'b1;
    tick();
    i_halt_instr = 1'b0;
    check("drain2_state", 32'(o_state), 3);
    tick();
    #2 i_reset = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(ctl()), 32'b00000);
    check("mid_rst_state", 32'(o_state), 0);
    check("mid_rst_cycle", o_cycle_count, 0);
    check("mid_rst_halted", 32'(o_halted), 0);
    @(negedge i_clock) i_reset = 1'b1;
    #1 check("post_rst_ctl", 32'(ctl()), 32'b11001);
    check("post_rst_stall", o_stall_count, 0);
    tick();
    check("post_rst_cycle", o_cycle_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
